pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the five-stage pipe: load-use stalls, branch flush, mult/div freeze, halt.
// RUN responses are same-cycle (Mealy); MD_BUSY and HALT are decoded from registered state.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        MemRead_EX,
  input  logic [4:0]  Rt_EX,
  input  logic        Branch_Taken_ID,
  input  logic        MulDiv_ID,
  input  logic        Halt_ID,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        ID_EX_Hold,
  output logic [1:0]  State,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_HALT    = 2'd2,
    ST_UNUSED  = 2'd3
  } state_t;

  localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_md_cnt;
  logic [7:0]  w_md_cnt_next;
  logic [15:0] r_stall_cnt;

  logic w_lu;
  logic w_pc_wr;
  logic w_ifid_wr;
  logic w_flush;
  logic w_bubble;
  logic w_hold;

  // Register 0 is hardwired, so a load into it never creates a dependency.
  always_comb begin
    w_lu = MemRead_EX && (Rt_EX != 5'd0) &&
           ((Rt_EX == Rs_ID) || (Rt_EX == Rt_ID));
  end

  always_comb begin
    w_next_state  = r_state;
    w_md_cnt_next = r_md_cnt;
    w_pc_wr       = 1'b0;
    w_ifid_wr     = 1'b0;
    w_flush       = 1'b0;
    w_bubble      = 1'b0;
    w_hold        = 1'b0;

    case (r_state)
      ST_MD_BUSY: begin
        w_hold = 1'b1;
        if (r_md_cnt == 8'd0) begin
          w_next_state = ST_RUN;
        end else begin
          w_md_cnt_next = r_md_cnt - 8'd1;
        end
      end

      ST_HALT: begin
        w_bubble = 1'b1;
      end

      default: begin
        // The unused encoding behaves as RUN and settles into RUN.
        w_next_state = ST_RUN;
        if (w_lu) begin
          w_bubble = 1'b1;
        end else if (Halt_ID) begin
          w_bubble     = 1'b1;
          w_next_state = ST_HALT;
        end else if (Branch_Taken_ID) begin
          w_pc_wr   = 1'b1;
          w_ifid_wr = 1'b1;
          w_flush   = 1'b1;
        end else if (MulDiv_ID) begin
          w_pc_wr       = 1'b1;
          w_ifid_wr     = 1'b1;
          w_next_state  = ST_MD_BUSY;
          w_md_cnt_next = MD_LOAD;
        end else begin
          w_pc_wr   = 1'b1;
          w_ifid_wr = 1'b1;
        end
      end
    endcase
  end

  // Reset forces every enable low immediately, independent of the clock.
  assign PCWrite      = Rst_n & w_pc_wr;
  assign IF_ID_Write  = Rst_n & w_ifid_wr;
  assign IF_ID_Flush  = Rst_n & w_flush;
  assign ID_EX_Bubble = Rst_n & w_bubble;
  assign ID_EX_Hold   = Rst_n & w_hold;
  assign State        = r_state;
  assign StallCount   = r_stall_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= ST_RUN;
      r_md_cnt    <= 8'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state  <= w_next_state;
      r_md_cnt <= w_md_cnt_next;
      if (!w_pc_wr && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule
